sam_video_addr: RTL and testbench

//  Video address generator upstream of the VDG core. Produces the display-memory byte address whose data the VDG samples on Data[7:0].

---
 rtl/sam_video_pkg.sv | 35 +++
 rtl/sam_edge_detect.sv | 38 +++
 rtl/sam_video_addr.sv | 153 +++++++++++++++
 tb/tb_sam_video_addr.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sam_video_pkg.sv
// Shared definitions for the SAM-style video address generator.
//  - mode_geo(): bytes-per-row / lines-per-row lookup by V mode
//  - state_e:    address FSM states
//  - PAGE_SHIFT: Foffset page size (512-byte pages)
package sam_video_pkg;

    localparam int PAGE_SHIFT = 9;

    typedef enum logic [1:0] {
        VBLANK = 2'd0,
        LINE   = 2'd1,
        HBLANK = 2'd2
    } state_e;

    // Row geometry: bpr = bytes fetched per row, rep = scanlines per row.
    typedef struct packed {
        logic [5:0] bpr;
        logic [3:0] rep;
    } geo_t;

    function automatic geo_t mode_geo(input logic [2:0] vmode);
        geo_t g;
        case (vmode)
            3'd0:    begin g.bpr = 6'd32; g.rep = 4'd12; end
            3'd1:    begin g.bpr = 6'd16; g.rep = 4'd3;  end
            3'd2:    begin g.bpr = 6'd32; g.rep = 4'd3;  end
            3'd3:    begin g.bpr = 6'd16; g.rep = 4'd2;  end
            3'd4:    begin g.bpr = 6'd32; g.rep = 4'd2;  end
            3'd5:    begin g.bpr = 6'd16; g.rep = 4'd1;  end
            default: begin g.bpr = 6'd32; g.rep = 4'd1;  end  // V6, V7 aliases V6
        endcase
        return g;
    endfunction

endpackage

// File: rtl/sam_edge_detect.sv
// Single-input synchroniser stage plus edge detector.
// Ports:
//  clk_i   clock
//  rst_n_i async active-low reset
//  d_i     raw input level
//  rise_o  one-cycle pulse: current sample 1, previous sample 0
//  fall_o  one-cycle pulse: current sample 0, previous sample 1
module sam_edge_detect (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic       smp_q;
    logic       prv_q;
    // Both sample regs clear to 0 on reset; an idle-high input (HSn/FSn)
    // would otherwise look like a rising edge right after release. Edges
    // are only trusted once smp_q and prv_q both hold real samples.
    logic [1:0] vld_pipe_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            smp_q      <= 1'b0;
            prv_q      <= 1'b0;
            vld_pipe_q <= 2'b00;
        end else begin
            smp_q      <= d_i;
            prv_q      <= smp_q;
            vld_pipe_q <= {vld_pipe_q[0], 1'b1};
        end
    end

    assign rise_o = vld_pipe_q[1] &  smp_q & ~prv_q;
    assign fall_o = vld_pipe_q[1] & ~smp_q &  prv_q;

endmodule

// File: rtl/sam_video_addr.sv
// Video address generator feeding the RAM address mux during video slots.
// Tracks VDG timing (DA0 fetch strobe, HSn, FSn) and applies SAM V-mode row
// geometry to produce the byte address the VDG samples next.
// Ports:
//  Clk        system clock (shared with the VDG core)
//  RSTn       async active-low reset
//  DA0        fetch strobe, one rising edge per byte consumed
//  HSn        horizontal sync, active low
//  FSn        field sync, active low
//  Vmode      row geometry select, latched at FSn fall
//  Foffset    display start page (512-byte pages), used at FSn fall
//  Addr       registered video byte address = RowBase + Col
//  RowRep     scanline index within the current character row
//  FrameStart one-Clk pulse coincident with the frame base reload
module sam_video_addr
    import sam_video_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int OFFS_W = 7
) (
    input  logic              Clk,
    input  logic              RSTn,
    input  logic              DA0,
    input  logic              HSn,
    input  logic              FSn,
    input  logic [2:0]        Vmode,
    input  logic [OFFS_W-1:0] Foffset,
    output logic [ADDR_W-1:0] Addr,
    output logic [3:0]        RowRep,
    output logic              FrameStart
);

    localparam int NUM_SIG = 3;  // [0]=DA0 [1]=HSn [2]=FSn

    logic [NUM_SIG-1:0] sig_raw;
    logic [NUM_SIG-1:0] rise;
    logic [NUM_SIG-1:0] fall;

    assign sig_raw = {FSn, HSn, DA0};

    for (genvar i = 0; i < NUM_SIG; i++) begin : g_edge
        sam_edge_detect u_edge (
            .clk_i   (Clk),
            .rst_n_i (RSTn),
            .d_i     (sig_raw[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    logic da0_rise, hs_fall, hs_rise, fs_fall, fs_rise;
    assign da0_rise = rise[0];
    assign hs_fall  = fall[1];
    assign hs_rise  = rise[1];
    assign fs_fall  = fall[2];
    assign fs_rise  = rise[2];

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] rowbase_q, rowbase_d;
    logic [4:0]        col_q,     col_d;
    logic [3:0]        rep_q,     rep_d;
    logic              fetched_q, fetched_d;
    logic [2:0]        vmode_q,   vmode_d;
    logic              fstart_q,  fstart_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;

    geo_t geo;
    // Geometry follows the latched mode so mid-frame Vmode writes wait for
    // the next field.
    assign geo = mode_geo(vmode_q);

    always_comb begin
        state_d   = state_q;
        rowbase_d = rowbase_q;
        col_d     = col_q;
        rep_d     = rep_q;
        fetched_d = fetched_q;
        vmode_d   = vmode_q;
        fstart_d  = 1'b0;

        // FSn fall wins over everything and is honoured from any state.
        // Foffset is only consumed here, so the RowBase reload is its latch.
        if (fs_fall) begin
            state_d   = VBLANK;
            rowbase_d = ADDR_W'(Foffset) << PAGE_SHIFT;
            col_d     = '0;
            rep_d     = '0;
            fetched_d = 1'b0;
            vmode_d   = Vmode;
            fstart_d  = 1'b1;
        end else begin
            case (state_q)
                VBLANK: begin
                    if (fs_rise) state_d = LINE;
                end
                LINE: begin
                    if (hs_fall) begin
                        // Row bookkeeping happens on the HSn fall itself;
                        // lines with no fetches are border and leave it alone.
                        state_d = HBLANK;
                        if (fetched_q) begin
                            if (rep_q == geo.rep - 4'd1) begin
                                rowbase_d = rowbase_q + ADDR_W'(geo.bpr);
                                rep_d     = '0;
                            end else begin
                                rep_d = rep_q + 4'd1;
                            end
                        end
                        col_d     = '0;
                        fetched_d = 1'b0;
                    end else if (da0_rise) begin
                        // Column saturates at the last byte of the row.
                        if ({1'b0, col_q} < geo.bpr - 6'd1) col_d = col_q + 5'd1;
                        fetched_d = 1'b1;
                    end
                end
                HBLANK: begin
                    if (hs_rise) state_d = LINE;
                end
                default: state_d = VBLANK;
            endcase
        end
    end

    assign addr_d = rowbase_d + ADDR_W'(col_d);

    always_ff @(posedge Clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= VBLANK;
            rowbase_q <= '0;
            col_q     <= '0;
            rep_q     <= '0;
            fetched_q <= 1'b0;
            vmode_q   <= '0;
            fstart_q  <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            rowbase_q <= rowbase_d;
            col_q     <= col_d;
            rep_q     <= rep_d;
            fetched_q <= fetched_d;
            vmode_q   <= vmode_d;
            fstart_q  <= fstart_d;
            addr_q    <= addr_d;
        end
    end

    assign Addr       = addr_q;
    assign RowRep     = rep_q;
    assign FrameStart = fstart_q;

endmodule

// File: tb/tb_sam_video_addr.sv
module tb_sam_video_addr;

    logic        Clk = 1'b0;
    logic        RSTn;
    logic        DA0;
    logic        HSn;
    logic        FSn;
    logic [2:0]  Vmode;
    logic [6:0]  Foffset;
    logic [15:0] Addr;
    logic [3:0]  RowRep;
    logic        FrameStart;

    int total = 0;
    int bad   = 0;

    sam_video_addr #(.ADDR_W(16), .OFFS_W(7)) dut (
        .Clk        (Clk),
        .RSTn       (RSTn),
        .DA0        (DA0),
        .HSn        (HSn),
        .FSn        (FSn),
        .Vmode      (Vmode),
        .Foffset    (Foffset),
        .Addr       (Addr),
        .RowRep     (RowRep),
        .FrameStart (FrameStart)
    );

    always #5 Clk = ~Clk;

    // Inputs change and outputs are sampled on the negedge; a pin change
    // takes effect after two posedges.
    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic da0_n(input int n);
        for (int i = 0; i < n; i++) begin
            DA0 = 1'b1; tick(1);
            DA0 = 1'b0; tick(1);
        end
    endtask

    task automatic hs_fall();
        HSn = 1'b0; tick(2);
    endtask

    task automatic hs_rise();
        HSn = 1'b1; tick(2);
    endtask

    task automatic line(input int n);
        da0_n(n); hs_fall(); hs_rise();
    endtask

    task automatic frame_fall(input logic [2:0] vm, input logic [6:0] fo);
        Vmode = vm; Foffset = fo;
        FSn = 1'b0; tick(2);
    endtask

    task automatic frame_rise();
        FSn = 1'b1; tick(2);
    endtask

    task automatic test_reset();
        RSTn = 1'b0; DA0 = 1'b0; HSn = 1'b1; FSn = 1'b1; Vmode = 3'd0; Foffset = 7'd0;
        tick(3);
        total++; if (Addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", Addr); end
        total++; if (RowRep !== 4'd0) begin bad++; $display("FAIL reset_rowrep got=%0d exp=0", RowRep); end
        total++; if (FrameStart !== 1'b0) begin bad++; $display("FAIL reset_fstart got=%b exp=0", FrameStart); end
        RSTn = 1'b1;
        tick(3);
    endtask

    task automatic test_frame_v6();
        frame_fall(3'd6, 7'd2);
        total++; if (FrameStart !== 1'b1) begin bad++; $display("FAIL v6_fstart got=%b exp=1", FrameStart); end
        total++; if (Addr !== 16'h0400) begin bad++; $display("FAIL v6_base got=%h exp=0400", Addr); end
        tick(1);
        total++; if (FrameStart !== 1'b0) begin bad++; $display("FAIL v6_fstart_pulse got=%b exp=0", FrameStart); end
        frame_rise();
        da0_n(32);
        total++; if (Addr !== 16'h041F) begin bad++; $display("FAIL v6_col_end got=%h exp=041f", Addr); end
        hs_fall();
        total++; if (Addr !== 16'h0420) begin bad++; $display("FAIL v6_row1 got=%h exp=0420", Addr); end
        hs_rise();
        for (int i = 1; i < 192; i++) line(32);
        total++; if (Addr !== 16'h1C00) begin bad++; $display("FAIL v6_192rows got=%h exp=1c00", Addr); end
    endtask

    task automatic test_reset_midline();
        frame_fall(3'd6, 7'd2);
        frame_rise();
        da0_n(18);
        total++; if (Addr !== 16'h0412) begin bad++; $display("FAIL mid_pre got=%h exp=0412", Addr); end
        #2 RSTn = 1'b0;
        #1;
        total++; if (Addr !== 16'h0000) begin bad++; $display("FAIL mid_rst_addr got=%h exp=0000", Addr); end
        total++; if (RowRep !== 4'd0) begin bad++; $display("FAIL mid_rst_rep got=%0d exp=0", RowRep); end
        tick(1);
        RSTn = 1'b1;
        tick(3);
        da0_n(3); hs_fall(); hs_rise(); da0_n(2);
        total++; if (Addr !== 16'h0000) begin bad++; $display("FAIL mid_hold got=%h exp=0000", Addr); end
        frame_fall(3'd6, 7'd2);
        total++; if (Addr !== 16'h0400) begin bad++; $display("FAIL mid_reload got=%h exp=0400", Addr); end
        total++; if (FrameStart !== 1'b1) begin bad++; $display("FAIL mid_fstart got=%b exp=1", FrameStart); end
        frame_rise();
    endtask

    task automatic test_v1();
        logic [15:0] exp_base [4];
        logic [3:0]  exp_rep  [4];
        exp_base = '{16'h0000, 16'h0000, 16'h0000, 16'h0010};
        exp_rep  = '{4'd0, 4'd1, 4'd2, 4'd0};
        frame_fall(3'd1, 7'd0);
        frame_rise();
        for (int i = 0; i < 4; i++) begin
            total++; if (Addr !== exp_base[i]) begin bad++; $display("FAIL v1_line%0d_addr got=%h exp=%h", i, Addr, exp_base[i]); end
            total++; if (RowRep !== exp_rep[i]) begin bad++; $display("FAIL v1_line%0d_rep got=%0d exp=%0d", i, RowRep, exp_rep[i]); end
            da0_n(16);
            if (i == 0) begin
                total++; if (Addr !== 16'h000F) begin bad++; $display("FAIL v1_col_end got=%h exp=000f", Addr); end
            end
            hs_fall(); hs_rise();
        end
    endtask

    task automatic test_v0_hold();
        frame_fall(3'd0, 7'd0);
        frame_rise();
        da0_n(40);
        total++; if (Addr !== 16'h001F) begin bad++; $display("FAIL v0_sat got=%h exp=001f", Addr); end
        hs_fall(); hs_rise();
        total++; if (Addr !== 16'h0000 || RowRep !== 4'd1) begin bad++; $display("FAIL v0_line1 got=%h/%0d exp=0000/1", Addr, RowRep); end
        for (int i = 1; i < 11; i++) line(1);
        total++; if (Addr !== 16'h0000 || RowRep !== 4'd11) begin bad++; $display("FAIL v0_line11 got=%h/%0d exp=0000/11", Addr, RowRep); end
        line(1);
        total++; if (Addr !== 16'h0020 || RowRep !== 4'd0) begin bad++; $display("FAIL v0_line12 got=%h/%0d exp=0020/0", Addr, RowRep); end
    endtask

    task automatic test_border();
        frame_fall(3'd6, 7'd0);
        frame_rise();
        for (int i = 0; i < 3; i++) line(0);
        total++; if (Addr !== 16'h0000 || RowRep !== 4'd0) begin bad++; $display("FAIL border got=%h/%0d exp=0000/0", Addr, RowRep); end
        da0_n(5);
        total++; if (Addr !== 16'h0005) begin bad++; $display("FAIL border_fetch got=%h exp=0005", Addr); end
        // DA0 rise landing with the HSn fall must be dropped
        DA0 = 1'b1; HSn = 1'b0; tick(1);
        DA0 = 1'b0; tick(1);
        total++; if (Addr !== 16'h0020) begin bad++; $display("FAIL coinc_row got=%h exp=0020", Addr); end
        hs_rise();
        // fresh line whose only DA0 collides with HSn fall: still a border line
        DA0 = 1'b1; HSn = 1'b0; tick(1);
        DA0 = 1'b0; tick(1);
        total++; if (Addr !== 16'h0020) begin bad++; $display("FAIL coinc_border got=%h exp=0020", Addr); end
        hs_rise();
        da0_n(1);
        total++; if (Addr !== 16'h0021) begin bad++; $display("FAIL coinc_col got=%h exp=0021", Addr); end
        hs_fall(); hs_rise();
    endtask

    task automatic test_wrap();
        frame_fall(3'd4, 7'h7F);
        total++; if (Addr !== 16'hFE00) begin bad++; $display("FAIL wrap_base got=%h exp=fe00", Addr); end
        frame_rise();
        for (int i = 0; i < 30; i++) line(1);
        total++; if (Addr !== 16'hFFE0 || RowRep !== 4'd0) begin bad++; $display("FAIL wrap_pre got=%h/%0d exp=ffe0/0", Addr, RowRep); end
        Vmode = 3'd6;
        line(1);
        total++; if (Addr !== 16'hFFE0 || RowRep !== 4'd1) begin bad++; $display("FAIL wrap_keepmode got=%h/%0d exp=ffe0/1", Addr, RowRep); end
        line(1);
        total++; if (Addr !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", Addr); end
        line(1);
        total++; if (Addr !== 16'h0000 || RowRep !== 4'd1) begin bad++; $display("FAIL wrap_still_v4 got=%h/%0d exp=0000/1", Addr, RowRep); end
        frame_fall(3'd6, 7'd0);
        frame_rise();
        line(1);
        total++; if (Addr !== 16'h0020 || RowRep !== 4'd0) begin bad++; $display("FAIL wrap_newmode got=%h/%0d exp=0020/0", Addr, RowRep); end
    endtask

    initial begin
        test_reset();
        test_frame_v6();
        test_reset_midline();
        test_v1();
        test_v0_hold();
        test_border();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
